// File: rtl/encoder_read_scheduler.sv
// Periodic encoder-read sequencer: issues oEn every PERIOD_CYC clocks, times out and retries reads,
// latches sin/cos on success and raises a sticky fault when retries run out. Option: WARN_REJECT_EN.
module encoder_read_scheduler #(
    parameter int unsigned PERIOD_CYC  = 2000,
    parameter int unsigned TIMEOUT_CYC = 1500,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iRun,
    input  logic        iFault_clr,
    input  logic        iDone,
    input  logic        iWarning,
    input  logic [15:0] iSin,
    input  logic [15:0] iCos,
    output logic        oEn,
    output logic [15:0] oSin,
    output logic [15:0] oCos,
    output logic        oValid,
    output logic        oBusy,
    output logic        oOverrun,
    output logic        oFault
);

    localparam int unsigned PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    RMAX  = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    retry_q, retry_d;
    logic          en_q, en_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          fault_q, fault_d;
    logic [15:0]   sin_q, sin_d;
    logic [15:0]   cos_q, cos_d;
    logic          tick;
    logic          accept;
    logic          fault_set;

`ifdef WARN_REJECT_EN
    assign accept = iDone & ~iWarning;
`else
    logic unused_warning;
    assign unused_warning = iWarning;
    assign accept         = iDone;
`endif

    assign tick = iRun && (cnt_q == PLAST);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        en_d      = 1'b0;
        valid_d   = 1'b0;
        ovr_d     = 1'b0;
        fault_set = 1'b0;

        if (!iRun)              cnt_d = '0;
        else if (cnt_q == PLAST) cnt_d = '0;
        else                    cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tick && !fault_q) begin
                    en_d    = 1'b1;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ovr_d = tick;
                // timeout counter stays at 0 through the oEn cycle itself
                tmo_d = en_q ? '0 : tmo_q + 1'b1;
                if (accept) begin
                    sin_d   = iSin;
                    cos_d   = iCos;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (iDone || (!en_q && (tmo_q == TLAST))) begin
                    if (retry_q < RMAX) begin
                        retry_d = retry_q + 1'b1;
                        tmo_d   = '0;
                        en_d    = 1'b1;
                    end else begin
                        fault_set = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        fault_d = fault_q;
        if (iFault_clr) fault_d = 1'b0;
        if (fault_set)  fault_d = 1'b1;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            fault_q <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            fault_q <= fault_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign oEn      = en_q;
    assign oValid   = valid_q;
    assign oOverrun = ovr_q;
    assign oFault   = fault_q;
    assign oSin     = sin_q;
    assign oCos     = cos_q;
    assign oBusy    = (state_q == S_WAIT);

endmodule

// File: tb/tb_encoder_read_scheduler.sv
// Bench for encoder_read_scheduler: directed timing scenarios with literal expectations, then
// randomized traffic checked every cycle against an event-level reference model.
module tb_encoder_read_scheduler;

    localparam int P = 20;
    localparam int T = 10;
    localparam int R = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iRun = 1'b0, iFault_clr = 1'b0, iDone = 1'b0, iWarning = 1'b0;
    logic [15:0] iSin = '0, iCos = '0;
    logic        oEn, oValid, oBusy, oOverrun, oFault;
    logic [15:0] oSin, oCos;

    encoder_read_scheduler #(.PERIOD_CYC(P), .TIMEOUT_CYC(T), .MAX_RETRY(R)) dut (
        .iClk(clk), .iRst_n(rst_n), .iRun(iRun), .iFault_clr(iFault_clr), .iDone(iDone),
        .iWarning(iWarning), .iSin(iSin), .iCos(iCos), .oEn(oEn), .oSin(oSin), .oCos(oCos),
        .oValid(oValid), .oBusy(oBusy), .oOverrun(oOverrun), .oFault(oFault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a read is "issued" at a cycle number and fails exactly T cycles later.
    localparam int M_IDLE = 0, M_WAIT = 1, M_HOLD = 2;
    int          mode = M_IDLE;
    longint      cyc = 0, issue = 0, run_age = 0;
    int          attempts = 0;
    bit          m_en = 0, m_val = 0, m_ovr = 0, m_fault = 0;
    logic [15:0] m_sin = '0, m_cos = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = M_IDLE; run_age = 0; attempts = 0;
            m_en = 0; m_val = 0; m_ovr = 0; m_fault = 0; m_sin = '0; m_cos = '0;
        end else begin
            bit tick, rejected, fset;
            tick = iRun && ((run_age % P) == P - 1);
`ifdef WARN_REJECT_EN
            rejected = iWarning;
`else
            rejected = 1'b0;
`endif
            fset = 0; m_en = 0; m_val = 0; m_ovr = 0;
            case (mode)
                M_IDLE: if (tick && !m_fault) begin
                    m_en = 1; issue = cyc + 1; attempts = 1; mode = M_WAIT;
                end
                M_WAIT: begin
                    m_ovr = tick;
                    if (iDone && !rejected) begin
                        m_sin = iSin; m_cos = iCos; m_val = 1; mode = M_HOLD;
                    end else if (iDone || cyc == issue + T) begin
                        if (attempts <= R) begin
                            attempts++; issue = cyc + 1; m_en = 1;
                        end else begin
                            fset = 1; mode = M_HOLD;
                        end
                    end
                end
                default: mode = M_IDLE;
            endcase
            if (iFault_clr) m_fault = 0;
            if (fset)       m_fault = 1;
            run_age = iRun ? run_age + 1 : 0;
        end
        cyc++;
    end

    bit cmp_on   = 0;
    int ovr_seen = 0;

    always @(negedge clk) begin
        if (oOverrun === 1'b1) ovr_seen++;
        if (cmp_on) begin
            chk("oEn",      32'(oEn),      32'(m_en));
            chk("oValid",   32'(oValid),   32'(m_val));
            chk("oBusy",    32'(oBusy),    32'(mode == M_WAIT));
            chk("oOverrun", 32'(oOverrun), 32'(m_ovr));
            chk("oFault",   32'(oFault),   32'(m_fault));
            chk("oSin",     32'(oSin),     32'(m_sin));
            chk("oCos",     32'(oCos),     32'(m_cos));
        end
    end

    // Datapath stand-in: answers each oEn with iDone after a chosen delay.
    int cd = -1;
    bit respond_en = 0, fixed_data = 0, clr_req = 0, force_done = 0;
    int dly_min = 5, dly_max = 5, warn_pct = 0;

    task automatic drive_cycle(input bit spurious);
        @(posedge clk);
        #2;
        iDone      = 1'b0;
        iFault_clr = clr_req;
        clr_req    = 0;
        if (fixed_data) begin
            iSin = 16'h1234; iCos = 16'h7FFF;
        end else begin
            iSin = 16'($urandom); iCos = 16'($urandom);
        end
        iWarning = ($urandom_range(99, 0) < warn_pct);
        if (oEn === 1'b1 && respond_en) cd = $urandom_range(dly_max, dly_min);
        if (cd == 0) begin
            iDone = 1'b1; cd = -1;
        end else if (cd > 0) begin
            cd--;
        end
        if (force_done) iDone = 1'b1;
        if (!iDone && spurious && $urandom_range(39, 0) == 0) iDone = 1'b1;
    endtask

    localparam int W_EN = 0, W_VALID = 1, W_FAULT = 2;

    task automatic wait_sig(input int which, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            drive_cycle(0);
            if ((which == W_EN && oEn === 1'b1) || (which == W_VALID && oValid === 1'b1) ||
                (which == W_FAULT && oFault === 1'b1)) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, ovr0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cmp_on = 1;
        chk("reset_en", 32'(oEn), 32'd0);
        chk("reset_fault", 32'(oFault), 32'd0);

        // Good reads every period
        iRun = 1'b1; fixed_data = 1; respond_en = 1; dly_min = 5; dly_max = 5; warn_pct = 0;
        wait_sig(W_EN, 100, n);    chk("first_en_latency", n, 20);
        wait_sig(W_VALID, 50, n);  chk("valid_after_en", n, 6);
        chk("sin_latched", 32'(oSin), 32'h1234);
        chk("cos_latched", 32'(oCos), 32'h7FFF);
        wait_sig(W_EN, 50, n);     chk("en_period", n, 14);
        wait_sig(W_VALID, 50, n);  chk("valid_after_en2", n, 6);

        // Datapath silent: three attempts then fault
        respond_en = 0;
        wait_sig(W_EN, 50, n);     chk("silent_first_en", n, 14);
        ovr0 = ovr_seen;
        wait_sig(W_EN, 50, n);     chk("retry1_gap", n, 11);
        wait_sig(W_EN, 50, n);     chk("retry2_gap", n, 11);
        wait_sig(W_FAULT, 50, n);  chk("fault_gap", n, 11);
        chk("overrun_count", 32'(ovr_seen - ovr0), 32'd1);
        chk("sin_kept", 32'(oSin), 32'h1234);
        wait_sig(W_EN, 60, n);     chk("no_en_while_fault", n, -1);

        // Clear fault, service resumes
        clr_req = 1; respond_en = 1;
        drive_cycle(0);
        wait_sig(W_EN, 40, n);     chk("en_after_clr", 32'(n > 0 && n <= 20), 32'd1);
        chk("fault_cleared", 32'(oFault), 32'd0);
        wait_sig(W_VALID, 50, n);  chk("valid_after_clr", n, 6);

        // Reset mid-WAIT, then a stale done pulse
        wait_sig(W_EN, 40, n);     chk("en_before_reset", 32'(n > 0), 32'd1);
        drive_cycle(0);
        chk("busy_mid_read", 32'(oBusy), 32'd1);
        rst_n = 1'b0; respond_en = 0; iRun = 1'b0; cd = -1;
        drive_cycle(0);
        drive_cycle(0);
        rst_n = 1'b1;
        force_done = 1;
        drive_cycle(0);
        force_done = 0;
        repeat (3) drive_cycle(0);
        chk("post_reset_sin", 32'(oSin), 32'd0);
        chk("post_reset_busy", 32'(oBusy), 32'd0);
        chk("post_reset_valid", 32'(oValid), 32'd0);

        // Randomized traffic
        fixed_data = 0; respond_en = 1; dly_min = 0; dly_max = 14; warn_pct = 30; iRun = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            drive_cycle(1);
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(799, 0) == 0) rst_n = 1'b0;
            if (iRun) begin
                if ($urandom_range(199, 0) == 0) iRun = 1'b0;
            end else if ($urandom_range(9, 0) == 0) begin
                iRun = 1'b1;
            end
            if ($urandom_range(99, 0) < 2) clr_req = 1;
        end
        drive_cycle(0);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
